rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between NREQ writeback sources (ALU, load unit, ...).
//  Uses round-robin arbitration with a valid/ready handshake per source.
//  Drives registered write-enable, address and data into the register file one cycle after a grant.
//  Optionally keeps a pending-write scoreboard that decode uses to stall on RAW hazards.
// PARAMETERS
//  NREQ     2   number of writeback requesters (2..8)
//  AW       5   register address width
//  DW       32  register data width
//  DROP_R0  1   1: writes to register 0 are accepted but never reach the register file
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  hold       in   1        1: grant nothing this cycle (all req_ready=0)
//  req_valid  in   NREQ     source i has a write pending
//  req_addr   in   NREQ*AW  source i destination register, slice [i*AW +: AW]
//  req_data   in   NREQ*DW  source i write data, slice [i*DW +: DW]
//  req_ready  out  NREQ     one-hot (or zero); source i transfer this cycle
//  rf_we      out  1        register-file write enable
//  rf_waddr   out  AW       register-file write address
//  rf_wdata   out  DW       register-file write data
//  rsv_valid  in   1        [RF_WB_SCOREBOARD_EN] reserve a destination at issue
//  rsv_addr   in   AW       [RF_WB_SCOREBOARD_EN] register to reserve
//  busy       out  2**AW    [RF_WB_SCOREBOARD_EN] bit r=1: write to r still pending
// BEHAVIOUR
//  - Reset (async): rf_we=0, rf_waddr=0, rf_wdata=0, rr pointer=0, busy=0. req_ready is combinational,
//    so it is 0 while rst=1.
//  - Arbitration (combinational): the winner is the first i with req_valid[i]=1, searching from ptr
//    upward with modulo-NREQ wrap. req_ready[winner]=1 unless hold=1 or rst=1.
//  - Transfer happens when req_valid[i] & req_ready[i].
//    - On a transfer, ptr <= winner+1 (mod NREQ). Otherwise ptr is unchanged.
//    - A source must hold valid, addr and data stable until it sees ready. Dropping valid early is illegal.
//  - Latency: one cycle. The edge that ends a transfer cycle loads rf_waddr/rf_wdata and sets rf_we=1.
//    rf_we=0 in any cycle following a non-transfer cycle. Full throughput: one write per cycle.
//  - Fairness: a continuously valid source is granted within NREQ cycles when hold=0.
//  - Register 0 with DROP_R0=1: the transfer completes (ready=1), but rf_we stays 0.
//    rf_waddr/rf_wdata still update.
//  - hold=1: no grant; ptr and any in-flight output are unaffected. A registered write already in the
//    output stage still completes.
//  - Reset mid-operation: the in-flight output write is cancelled (rf_we=0 immediately). Sources re-present.
// CONFIGURATION
//  Macro RF_WB_SCOREBOARD_EN defined:
//   - busy[r] is set at a clock edge when rsv_valid=1 and rsv_addr=r (r!=0).
//   - busy[r] is cleared at the edge that loads rf_we=1 with rf_waddr=r.
//   - Set and clear of the same r at the same edge: set wins.
//   - busy[0] is always 0.
//   - Reserving an already-busy register keeps it busy. Counts are not kept; one outstanding write
//     per register is the issue-side rule.
//  Macro undefined: rsv_valid, rsv_addr and busy ports are absent and no scoreboard flops exist.
// STRUCTURE
//  - Shared package rf_pkg holds RF_AW=5, RF_DW=32, RF_DEPTH=32 and ZERO_REG=0.
//  - Sub-module rr_arbiter #(N): combinational rotating-priority pick. Inputs req[N], ptr; outputs
//    gnt[N] one-hot and gnt_idx.
//  - This module holds the pointer register, the output stage and the scoreboard.
// TESTING
//  1. Reset: assert rst mid-cycle -> rf_we=0, busy=0 asynchronously; after release with
//     req_valid=0, rf_we stays 0.
//  2. Single write: src0 addr=5, data=0xDEADBEEF, valid 1 cycle -> ready0=1 that cycle;
//     next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF.
//  3. Contention, NREQ=2, both valid continuously:
//     - grants alternate 0,1,0,1;
//     - rf_we=1 every cycle;
//     - no source waits more than 2 cycles.
//  4. R0 drop: src1 writes addr=0, data=0x1234 -> ready1=1, rf_we stays 0 next cycle.
//  5. hold: both valid, hold=1 for 3 cycles -> req_ready=0; ptr unchanged; grant order resumes as before.
//  6. Scoreboard (macro on):
//     - rsv addr=7 -> busy[7]=1;
//     - src0 writes 7 -> busy[7]=0 at the rf_we edge;
//     - rsv 7 at the same edge as that write -> busy[7] stays 1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants for the writeback path.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;
  localparam int ZERO_REG = 0;

endpackage : rf_pkg

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or above ptr (wrapping) wins.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_idx;

  // NOTE: every output is defaulted first so no path through the loop can infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && req[w_idx]) begin
        any        = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
      w_idx = (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule : rr_arbiter

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port.
// Define RF_WB_SCOREBOARD_EN to add the pending-write scoreboard (rsv_valid/rsv_addr/busy).
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata
`ifdef RF_WB_SCOREBOARD_EN
  ,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_addr,
  output logic [2**AW-1:0]   busy
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic            w_any;
  logic            w_xfer;
  logic            w_we_next;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // Ready is combinational, so reset must gate it directly rather than through a flop.
  assign w_xfer    = w_any & ~hold & ~rst;
  assign req_ready = w_xfer ? w_gnt : '0;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // A transfer to r0 still completes, but is never presented as a write.
  assign w_we_next = w_xfer & ~(DROP_R0 && (w_sel_addr == AW'(ZERO_REG)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_we_next;
      if (w_xfer) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

`ifdef RF_WB_SCOREBOARD_EN
  logic [2**AW-1:0] r_busy;
  logic [2**AW-1:0] w_busy_next;

  // Clear before set so a same-edge reserve of the retiring register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_we_next) begin
      w_busy_next[w_sel_addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != AW'(ZERO_REG))) begin
      w_busy_next[rsv_addr] = 1'b1;
    end
    w_busy_next[ZERO_REG] = 1'b0;
  end

  // NOTE: the scoreboard is a plain flop vector, so it is reset like any other control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy = r_busy;
`endif

endmodule : rf_wb_arbiter
